// File: rtl/stack_arbiter_if.sv
// Handshake and stack-side signal bundle for stack_arbiter.
// The master modport is the requester/stack environment; slave is the arbiter.
interface stack_arbiter_if #(parameter int width = 8);
  logic             req0;
  logic             req1;
  logic             op0;
  logic             op1;
  logic [width-1:0] wdata0;
  logic [width-1:0] wdata1;
  logic             ack0;
  logic             ack1;
  logic             err0;
  logic             err1;
  logic [width-1:0] rdata;
  logic             busy;
  logic [7:0]       err_cnt;
  logic             stk_en;
  logic             stk_c;
  logic [width-1:0] stk_push;
  logic [width-1:0] stk_peek;
  logic             stk_full;
  logic             stk_not_empty;

  modport master (
    output req0, req1, op0, op1, wdata0, wdata1, stk_peek, stk_full, stk_not_empty,
    input  ack0, ack1, err0, err1, rdata, busy, err_cnt, stk_en, stk_c, stk_push
  );

  modport slave (
    input  req0, req1, op0, op1, wdata0, wdata1, stk_peek, stk_full, stk_not_empty,
    output ack0, ack1, err0, err1, rdata, busy, err_cnt, stk_en, stk_c, stk_push
  );
endinterface

// File: rtl/stack_arbiter.sv
// Two-requester arbiter/sequencer for the hardware stack: one grant at a time, one-cycle stack strobe.
// Optional macro STACK_ARB_RR_EN selects round-robin arbitration; default is fixed priority (requester 0).
module stack_arbiter #(
  parameter int width = 8
) (
  input  logic            clk,
  input  logic            clr_n,
  stack_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_op;
  logic             r_id;
  logic             r_err;
  logic [width-1:0] r_hold;
`ifdef STACK_ARB_RR_EN
  logic             r_last;
`endif

  logic             w_gnt;
  logic             w_gnt_id;
  logic             w_gnt_op;
  logic             w_gnt_err;
  logic [width-1:0] w_gnt_wdata;
  logic             w_resp;
  logic             w_resp_id;
  logic             w_resp_err;
  logic             w_resp_pop_ok;

  // Winner selection and overflow/underflow pre-check against the stack's current flags
  always_comb begin
    w_gnt_id = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef STACK_ARB_RR_EN
      w_gnt_id = ~r_last;
`else
      w_gnt_id = 1'b0;
`endif
    end else if (bus.req1) begin
      w_gnt_id = 1'b1;
    end else begin
      w_gnt_id = 1'b0;
    end
    w_gnt       = (r_state == S_IDLE) && (bus.req0 || bus.req1);
    w_gnt_op    = w_gnt_id ? bus.op1 : bus.op0;
    w_gnt_wdata = w_gnt_id ? bus.wdata1 : bus.wdata0;
    w_gnt_err   = w_gnt_op ? bus.stk_full : ~bus.stk_not_empty;
  end

  // Next-state logic plus the id/error that accompany the response pulse
  always_comb begin
    w_next        = r_state;
    w_resp_id     = r_id;
    w_resp_err    = r_err;
    w_resp_pop_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt) begin
          w_next     = w_gnt_err ? S_RESP : S_ISSUE;
          w_resp_id  = w_gnt_id;
          w_resp_err = w_gnt_err;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE:  w_next = S_SETTLE;
      S_SETTLE: begin
        w_next        = S_RESP;
        w_resp_pop_ok = ~r_op;
      end
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_resp = (w_next == S_RESP);

  // State, latched request and all registered outputs; outputs are loaded from the next state
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state      <= S_IDLE;
      r_op         <= 1'b0;
      r_id         <= 1'b0;
      r_err        <= 1'b0;
      r_hold       <= {width{1'b0}};
`ifdef STACK_ARB_RR_EN
      r_last       <= 1'b1;
`endif
      bus.ack0     <= 1'b0;
      bus.ack1     <= 1'b0;
      bus.err0     <= 1'b0;
      bus.err1     <= 1'b0;
      bus.rdata    <= {width{1'b0}};
      bus.busy     <= 1'b0;
      bus.err_cnt  <= 8'd0;
      bus.stk_en   <= 1'b0;
      bus.stk_c    <= 1'b0;
      bus.stk_push <= {width{1'b0}};
    end else begin
      r_state <= w_next;
      if (w_gnt) begin
        r_op  <= w_gnt_op;
        r_id  <= w_gnt_id;
        r_err <= w_gnt_err;
        if (!w_gnt_op) begin
          r_hold <= bus.stk_peek;
        end
`ifdef STACK_ARB_RR_EN
        r_last <= w_gnt_id;
`endif
      end
      bus.stk_en <= (w_next == S_ISSUE);
      bus.stk_c  <= (w_next == S_ISSUE) && w_gnt_op;
      if ((w_next == S_ISSUE) && w_gnt_op) begin
        bus.stk_push <= w_gnt_wdata;
      end
      bus.busy <= (w_next != S_IDLE);
      bus.ack0 <= w_resp && !w_resp_id;
      bus.ack1 <= w_resp && w_resp_id;
      bus.err0 <= w_resp && !w_resp_id && w_resp_err;
      bus.err1 <= w_resp && w_resp_id && w_resp_err;
      // Holding register only moves on a successful pop, so rdata stays valid until the next one
      if (w_resp && w_resp_pop_ok) begin
        bus.rdata <= r_hold;
      end
      if (w_resp && w_resp_err && (bus.err_cnt != 8'hFF)) begin
        bus.err_cnt <= bus.err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a depth-1 stack model on the stack side.
module tb_stack_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  stack_arbiter_if #(.width(W)) bus();

  stack_arbiter #(.width(W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  // Depth-1 stack: registered flags/peek, not cleared by the arbiter reset
  logic         m_full = 1'b0;
  logic [W-1:0] m_data = '0;
  assign bus.stk_peek      = m_data;
  assign bus.stk_full      = m_full;
  assign bus.stk_not_empty = m_full;
  always @(posedge clk) begin
    if (bus.stk_en) begin
      if (bus.stk_c) begin
        m_data <= bus.stk_push;
        m_full <= 1'b1;
      end else begin
        m_full <= 1'b0;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         id;
    logic         op;
    logic [W-1:0] wdata;
    logic         exp_err;
    logic [W-1:0] exp_rdata;
    int           exp_lat;
    logic [7:0]   exp_cnt;
    logic         exp_ne;
  } vec_t;

  vec_t vecs[9];

  task automatic do_req(input logic id, input logic op, input logic [W-1:0] wd,
                        output int lat, output logic g_err, output logic [W-1:0] g_rd,
                        output int en_cnt, output logic en_ok, output logic wrong_ack);
    lat = -1; g_err = 1'b0; g_rd = '0; en_cnt = 0; en_ok = 1'b1; wrong_ack = 1'b0;
    @(negedge clk);
    if (id) begin bus.req1 = 1'b1; bus.op1 = op; bus.wdata1 = wd; end
    else    begin bus.req0 = 1'b1; bus.op0 = op; bus.wdata0 = wd; end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.stk_en) begin
        en_cnt++;
        en_ok = en_ok && (bus.stk_c === op) && (!op || (bus.stk_push === wd));
      end
      if ((id ? bus.ack0 : bus.ack1) === 1'b1) wrong_ack = 1'b1;
      if ((id ? bus.ack1 : bus.ack0) === 1'b1) begin
        lat   = k;
        g_err = id ? bus.err1 : bus.err0;
        g_rd  = bus.rdata;
        break;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(posedge clk); #1;
    if (bus.stk_en) en_cnt++;
  endtask

  int           lat;
  logic         g_err;
  logic [W-1:0] g_rd;
  int           en_cnt;
  logic         en_ok;
  logic         wrong_ack;
  logic         all_ok;
  logic         g_seq[4];
  logic         e_seq[4];
  int           n_g;

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.op0 = 1'b0; bus.op1 = 1'b0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    clr_n = 1'b0;

    //               id    op    wdata  err   rdata  lat cnt   ne
    vecs[0] = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 3, 8'd0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h3C, 3, 8'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 3, 8'd0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hA5, 3, 8'd0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1, 8'd1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 3, 8'd1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 8'h22, 1'b1, 8'h00, 1, 8'd2, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h11, 3, 8'd2, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1, 8'd3, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.busy, bus.stk_en, bus.stk_c}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_push", bus.stk_push, 32'd0);
    check("rst_errcnt", bus.err_cnt, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].id, vecs[i].op, vecs[i].wdata, lat, g_err, g_rd, en_cnt, en_ok, wrong_ack);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_err", i), g_err, vecs[i].exp_err);
      if (!vecs[i].op && !vecs[i].exp_err)
        check($sformatf("v%0d_rdata", i), g_rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_en_cnt", i), en_cnt, vecs[i].exp_err ? 0 : 1);
      check($sformatf("v%0d_en_lines", i), en_ok, 1'b1);
      check($sformatf("v%0d_other_ack", i), wrong_ack, 1'b0);
      check($sformatf("v%0d_errcnt", i), bus.err_cnt, vecs[i].exp_cnt);
      check($sformatf("v%0d_stack_ne", i), m_full, vecs[i].exp_ne);
      check($sformatf("v%0d_busy_after", i), bus.busy, 1'b0);
    end

    // Drive the error counter into saturation: 3 + 252 = 255, then 48 more must hold it
    all_ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      do_req(1'b0, 1'b0, 8'h00, lat, g_err, g_rd, en_cnt, en_ok, wrong_ack);
      all_ok = all_ok && (lat == 1) && g_err && (en_cnt == 0);
      if (i == 251) check("errcnt_reach_255", bus.err_cnt, 32'd255);
    end
    check("err_burst_ok", all_ok, 1'b1);
    check("errcnt_saturated", bus.err_cnt, 32'd255);

    // Fresh reset so the first contention is the first after reset
    @(negedge clk); clr_n = 1'b0;
    @(negedge clk); clr_n = 1'b1;
    @(negedge clk);
    bus.op0 = 1'b0; bus.op1 = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    n_g = 0;
    for (int k = 0; k < 40 && n_g < 4; k++) begin
      @(posedge clk); #1;
      if (bus.ack0 === 1'b1) begin g_seq[n_g] = 1'b0; n_g++; end
      else if (bus.ack1 === 1'b1) begin g_seq[n_g] = 1'b1; n_g++; end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
`ifdef STACK_ARB_RR_EN
    e_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    e_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    check("contention_grants", n_g, 4);
    for (int i = 0; i < n_g; i++) check($sformatf("grant%0d", i), g_seq[i], e_seq[i]);
    @(posedge clk); #1;
    check("contention_errcnt", bus.err_cnt, 32'd4);

    // Reset during SETTLE of a push: outputs clear asynchronously, no ack follows
    @(negedge clk);
    bus.req0 = 1'b1; bus.op0 = 1'b1; bus.wdata0 = 8'h5A;
    @(posedge clk); #1;
    check("abort_issue_en", {bus.stk_en, bus.stk_c, bus.stk_push}, {22'd0, 1'b1, 1'b1, 8'h5A});
    @(posedge clk); #2;
    check("abort_settle_busy", bus.busy, 1'b1);
    clr_n = 1'b0;
    #1;
    check("abort_outs_zero",
          {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.busy, bus.stk_en, bus.stk_c,
           bus.rdata, bus.stk_push, bus.err_cnt}, 32'd0);
    bus.req0 = 1'b0;
    @(negedge clk); clr_n = 1'b1;
    all_ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.busy !== 1'b0) all_ok = 1'b0;
    end
    check("abort_no_ack", all_ok, 1'b1);
    do_req(1'b0, 1'b0, 8'h00, lat, g_err, g_rd, en_cnt, en_ok, wrong_ack);
    check("post_abort_lat", lat, 3);
    check("post_abort_err", g_err, 1'b0);
    check("post_abort_rdata", g_rd, 32'h5A);
    check("post_abort_en", en_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Two-port request arbiter and sequencer for the processor's hardware `stack` block. It lets two requesters share one stack through a req/ack handshake:

- requester 0: control unit CALL/RET
- requester 1: interrupt unit entry/exit

It grants one request at a time and drives the stack's `en`/`c`/`push` lines for exactly one cycle per operation. Overflow and underflow are rejected before the stack is touched, and the popped value is returned to the requester.

## Interface
Parameters:
- `width`, 8, data width; must match the attached stack.

Ports:
- `clk` input 1: system clock, rising edge.
- `clr_n` input 1: asynchronous, active-low reset.
- `req0`, `req1` input 1: request from requester 0 / 1, held high until ack.
- `op0`, `op1` input 1: operation; 1 = push, 0 = pop. Stable while req is high.
- `wdata0`, `wdata1` input width: push data. Stable while req is high.
- `ack0`, `ack1` output 1: one-cycle completion pulse to requester 0 / 1.
- `err0`, `err1` output 1: valid with ack; 1 = rejected (push when full, pop when empty).
- `rdata` output width: popped value, valid in the ack cycle of a successful pop.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `err_cnt` output 8: saturating count of rejected requests.
- `stk_en` output 1: drives stack `en`.
- `stk_c` output 1: drives stack `c`; 1 = push.
- `stk_push` output width: drives stack `push`.
- `stk_peek` input width: from stack `peek`.
- `stk_full` input 1: from stack `full`.
- `stk_not_empty` input 1: from stack `not_empty`.

## Operation
- All outputs are registered.
- Reset values:
  - `ack*`, `err*`, `busy`, `stk_en`, `stk_c`: 0
  - `rdata`, `stk_push`: 0
  - `err_cnt`: 0
  - FSM: IDLE
  - last-grant pointer: 1
- FSM states: IDLE, ISSUE, SETTLE, RESP.
- IDLE: if any req is high, select a winner and latch its op, wdata and id.
  - Pop: also latch `stk_peek` into the `rdata` holding register.
  - Push with `stk_full`=1, or pop with `stk_not_empty`=0: set the error flag and go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: `stk_en`=1 and `stk_c`=op; for a push, `stk_push`=wdata. Go to SETTLE.
- SETTLE: `stk_en`=0. This cycle lets the stack's registered `full`/`not_empty`/`peek` update. Go to RESP.
- RESP: pulse `ack` of the latched id, with `err` = error flag.
  - `rdata` is driven for a successful pop.
  - If the error flag is set, increment `err_cnt`, saturating at 255.
  - Return to IDLE.
- `stk_en` is high for at most one cycle per grant and never on a rejected request.
- Each requester drops req in the cycle after its ack. A req still high in IDLE is treated as a new request.
- The arbiter never drives the stack's `clr`. A stack clear while `busy`=1 is a system-level error; no recovery is required.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous) and the in-flight request is dropped with no ack. The requester must re-issue.

## Timing
- Success latency: req sampled high in IDLE at edge t; `stk_en` high in cycle t+1; ack in cycle t+3. Next grant no earlier than t+4.
- Error latency: ack with `err`=1 in cycle t+1, no stack access.
- Sustained throughput: one successful operation per 4 cycles.
- The `rdata` holding register is stable from the ack cycle until the next pop ack.

## Configuration
- `STACK_ARB_RR_EN`
  - Defined: round-robin arbitration. On simultaneous requests, grant the requester not granted last; the pointer updates on every grant, including errors. First contention after reset grants requester 0.
  - Undefined: fixed priority, requester 0 always wins. The pointer is not implemented.

## Test plan
- Reset, then req0 push 0x3C on an empty stack -> `stk_en` pulse with `stk_c`=1 and `stk_push`=0x3C in cycle t+1; ack0 at t+3 with err0=0.
- Push 0xA5, then req1 pop -> rdata=0xA5 and ack1 at t+3 with err1=0; afterwards `stk_not_empty`=0.
- Pop on an empty stack -> ack0 at t+1 with err0=1, no `stk_en` pulse, `err_cnt`=1. Drive 300 such errors -> `err_cnt` holds at 255.
- Fill the stack (depth 1: 1 push sets full), then push -> err=1 and stack contents unchanged.
- req0 and req1 high together for 4 grants:
  - With `STACK_ARB_RR_EN`: grants alternate 0,1,0,1.
  - Without it: requester 0 is granted every time while it keeps requesting.
- Assert `clr_n` low during SETTLE -> all outputs 0 in the same cycle, no ack. After release, a new req0 pop completes normally.
